tpu_matmul_seq: RTL and testbench
=================================

# tpu_matmul_seq

Parametrised successor to the fixed TPU core behind the TinyTapeout top level. It computes C = A·B for signed 8-bit N×N matrices with N×N parallel MAC units. Operands are loaded byte-serially over `ui_in` with a valid strobe, and results are streamed out byte-serially on `uo_out` under a valid/ack handshake. It drops into the same pin-level slot as the existing `tpu` instance, which owns all 8-bit user I/O.

## Interface
- `N`, default 2: matrix dimension; legal range 1..4.
- `ACC_W`, default 16+$clog2(N)+1: signed accumulator width per C element.
- `OUT_BYTES`, default (ACC_W+7)/8: bytes streamed per C element.
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-high reset.
- `ena` input 1: when low, all state is frozen (no handshake accepted, no MAC step); outputs hold.
- `ui_in` input 8: operand byte, signed two's complement.
- `uio_in` input 8: [3] `in_valid`, [4] `out_ack`, [5] `abort`; other bits ignored.
- `uo_out` output 8: result byte; 0 whenever `out_valid` is low.
- `uio_out` output 8: [0] `load_ready`, [1] `busy`, [2] `out_valid`; [7:3] = 0.
- `uio_oe` output 8: constant 8'b0000_0111.

## Operation
- States: LOAD, COMPUTE, OUTPUT. Reset enters LOAD with the byte counter, k counter and accumulators cleared.
- LOAD (`load_ready`=1):
  - Each edge with `ena && in_valid` stores `ui_in` and increments the byte counter.
  - Bytes 0..N²-1 fill A row-major. Bytes N²..2N²-1 fill B row-major.
  - Acceptance of byte 2N²-1 moves to COMPUTE and clears all accumulators.
- COMPUTE (`busy`=1):
  - One step per enabled cycle, k = 0..N-1: C[i][j] += A[i][k]*B[k][j] for all i,j.
  - Products are 16-bit signed, sign-extended to ACC_W. No saturation; ACC_W is sized so overflow is impossible.
  - After step k=N-1 the block moves to OUTPUT, element index 0, byte index 0.
- OUTPUT (`out_valid`=1):
  - Elements stream row-major. Each element is sent as OUT_BYTES bytes, little-endian, sign-extended to 8·OUT_BYTES bits.
  - The current byte is held on `uo_out` until an edge with `ena && out_ack`. That edge advances to the next byte.
  - Ack of the last byte of C[N-1][N-1] returns the block to LOAD, clears the byte counter, and drops `out_valid` in the same edge.
- `abort`: on any enabled edge, returns to LOAD from any state and clears counters and accumulators. `abort` has priority over `in_valid` and `out_ack`.
- Status bits are one-hot. Exactly one of `load_ready`, `busy`, `out_valid` is high at any time.

## Timing
- Reset values: `uo_out`=0x00, `uio_out`=0x01, `uio_oe`=0x07, state LOAD.
- Reset asserted mid-COMPUTE or mid-OUTPUT: outputs return to reset values immediately (asynchronous), with no partial output.
- Byte 2N²-1 accepted at edge t:
  - `busy`=1 from t to t+N.
  - `out_valid`=1 and first byte on `uo_out` from edge t+N, assuming `ena` stays high.
- Output rate is at most one byte per cycle. With `out_ack` held high, a full readout takes N²·OUT_BYTES cycles.
- `in_valid` outside LOAD and `out_ack` outside OUTPUT are ignored and have no side effects.
- Low `ena` stretches any phase cycle-for-cycle. The COMPUTE k counter does not advance while `ena` is low.
- `uo_out` and `uio_out` are registered. The outputs change only on clock edges or on reset.

## Test plan
- Reset: assert `reset` mid-operation → `uo_out`=0x00 and `uio_out`=0x01 immediately. After release, loading restarts at A[0][0].
- N=2 basic: A=[[1,2],[3,4]], B=[[5,6],[7,8]], `out_ack` held high.
  - C=[[19,22],[43,50]] with ACC_W=18, OUT_BYTES=3.
  - Byte stream: 13 00 00 16 00 00 2B 00 00 32 00 00.
  - `out_valid` rises exactly N=2 cycles after the last load edge.
- Signed extremes, N=2: all A and B entries = 0x80 (−128) → every C = 32768 → bytes 00 80 00. Then A all 0x80 and B all 0x7F → every C = −32512 → bytes 00 81 FF.
- Handshake and backpressure:
  - Gaps in `in_valid` and random `out_ack` stalls give the same stream as the basic test.
  - `uo_out` is stable while unacked.
  - `in_valid` pulsed during COMPUTE/OUTPUT changes nothing.
- Abort and `ena`:
  - `abort` after 5 loaded bytes → `load_ready`=1 and the next 8 bytes form a fresh A/B.
  - `ena`=0 for 3 cycles during COMPUTE → `out_valid` is delayed by exactly 3 cycles.
- Parameter sweep: N=1 and N=4 with random operands, checked against a reference model → results match; N=4 gives ACC_W=19, 3 bytes per element.

Source files
------------

// File: rtl/tpu_matmul_seq.sv
// rtl/tpu_matmul_seq.sv - byte-serial signed NxN matrix multiply with N*N parallel MACs
module tpu_matmul_seq #(
  parameter int N         = 2,
  parameter int ACC_W     = 16 + $clog2(N) + 1,
  parameter int OUT_BYTES = (ACC_W + 7) / 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NN    = N * N;
  localparam int OPS   = 2 * NN;
  localparam int BC_W  = $clog2(OPS);
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int E_W   = (NN > 1) ? $clog2(NN) : 1;
  localparam int OB_W  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int EXT_W = 8 * OUT_BYTES;

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(OPS - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(N - 1);
  localparam logic [E_W-1:0]  E_LAST  = E_W'(NN - 1);
  localparam logic [OB_W-1:0] OB_LAST = OB_W'(OUT_BYTES - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  logic in_valid;
  logic out_ack;
  logic abort;
  logic unused_uio;

  assign in_valid   = uio_in[3];
  assign out_ack    = uio_in[4];
  assign abort      = uio_in[5];
  assign unused_uio = ^{uio_in[7:6], uio_in[2:0]};
  assign uio_oe     = 8'b0000_0111;

  state_t                  state, state_n;
  logic [BC_W-1:0]         bcnt, bcnt_n;
  logic [K_W-1:0]          k, k_n;
  logic [E_W-1:0]          elem, elem_n;
  logic [OB_W-1:0]         bidx, bidx_n;
  logic signed [ACC_W-1:0] acc   [NN];
  logic signed [ACC_W-1:0] acc_n [NN];
  logic [7:0]              op_mem [OPS];
  logic                    load_we;
  logic signed [7:0]       a_col [N];
  logic signed [7:0]       b_row [N];
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [EXT_W-1:0] ext;
  logic [7:0]              out_byte_n;

  // Column k of A and row k of B feed every MAC in this step
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_col[i] = '0;
      b_row[i] = '0;
    end
    for (int kk = 0; kk < N; kk++) begin
      if (k == K_W'(kk)) begin
        for (int i = 0; i < N; i++) begin
          a_col[i] = op_mem[i*N + kk];
          b_row[i] = op_mem[NN + kk*N + i];
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    k_n     = k;
    elem_n  = elem;
    bidx_n  = bidx;
    acc_n   = acc;
    load_we = 1'b0;
    if (ena) begin
      if (abort) begin
        state_n = LOAD;
        bcnt_n  = '0;
        k_n     = '0;
        elem_n  = '0;
        bidx_n  = '0;
        for (int e = 0; e < NN; e++) acc_n[e] = '0;
      end else begin
        case (state)
          LOAD: begin
            if (in_valid) begin
              load_we = 1'b1;
              if (bcnt == BC_LAST) begin
                state_n = COMPUTE;
                bcnt_n  = '0;
                k_n     = '0;
                for (int e = 0; e < NN; e++) acc_n[e] = '0;
              end else begin
                bcnt_n = bcnt + BC_W'(1);
              end
            end
          end
          COMPUTE: begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                acc_n[i*N + j] = acc[i*N + j] + ACC_W'(16'(a_col[i]) * 16'(b_row[j]));
              end
            end
            if (k == K_LAST) begin
              state_n = OUTPUT;
              k_n     = '0;
              elem_n  = '0;
              bidx_n  = '0;
            end else begin
              k_n = k + K_W'(1);
            end
          end
          OUTPUT: begin
            if (out_ack) begin
              if (bidx == OB_LAST) begin
                bidx_n = '0;
                if (elem == E_LAST) begin
                  state_n = LOAD;
                  bcnt_n  = '0;
                  elem_n  = '0;
                end else begin
                  elem_n = elem + E_W'(1);
                end
              end else begin
                bidx_n = bidx + OB_W'(1);
              end
            end
          end
          default: state_n = LOAD;
        endcase
      end
    end
  end

  // The output register is loaded from next-state values so the first byte appears with the last MAC step
  always_comb begin
    acc_sel = '0;
    for (int e = 0; e < NN; e++) begin
      if (elem_n == E_W'(e)) acc_sel = acc_n[e];
    end
    ext        = EXT_W'(acc_sel);
    out_byte_n = 8'h00;
    if (state_n == OUTPUT) begin
      for (int b = 0; b < OUT_BYTES; b++) begin
        if (bidx_n == OB_W'(b)) out_byte_n = ext[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LOAD;
      bcnt    <= '0;
      k       <= '0;
      elem    <= '0;
      bidx    <= '0;
      for (int e = 0; e < NN; e++) acc[e] <= '0;
      uo_out  <= 8'h00;
      uio_out <= 8'h01;
    end else begin
      state   <= state_n;
      bcnt    <= bcnt_n;
      k       <= k_n;
      elem    <= elem_n;
      bidx    <= bidx_n;
      for (int e = 0; e < NN; e++) acc[e] <= acc_n[e];
      uo_out  <= out_byte_n;
      uio_out <= {5'b00000, state_n == OUTPUT, state_n == COMPUTE, state_n == LOAD};
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      for (int e = 0; e < OPS; e++) begin
        if (bcnt == BC_W'(e)) op_mem[e] <= ui_in;
      end
    end
  end

endmodule

// File: tb/tb_tpu_matmul_seq.sv
// tb/tb_tpu_matmul_seq.sv - self-checking bench for tpu_matmul_seq at N=2, N=1 and N=4
module tb_tpu_matmul_seq;

  localparam int ND = 3;
  localparam int OB = 3;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    string      name;
    logic [7:0] ops [8];
    logic [7:0] exp [12];
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ui  [ND];
  logic       iv  [ND];
  logic       ack [ND];
  logic       ab  [ND];
  logic       en  [ND];
  logic [7:0] uo  [ND];
  logic [7:0] uio [ND];
  logic [7:0] oe  [ND];

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  tpu_matmul_seq #(.N(2)) dut0 (
    .clk(clk), .reset(reset), .ena(en[0]), .ui_in(ui[0]),
    .uio_in({2'b11, ab[0], ack[0], iv[0], 3'b111}),
    .uo_out(uo[0]), .uio_out(uio[0]), .uio_oe(oe[0])
  );
  tpu_matmul_seq #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .ena(en[1]), .ui_in(ui[1]),
    .uio_in({2'b00, ab[1], ack[1], iv[1], 3'b010}),
    .uo_out(uo[1]), .uio_out(uio[1]), .uio_oe(oe[1])
  );
  tpu_matmul_seq #(.N(4)) dut2 (
    .clk(clk), .reset(reset), .ena(en[2]), .ui_in(ui[2]),
    .uio_in({2'b10, ab[2], ack[2], iv[2], 3'b001}),
    .uo_out(uo[2]), .uio_out(uio[2]), .uio_oe(oe[2])
  );

  function automatic int dim(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: plain integer matrix product, each element sent as 3 little-endian bytes
  function automatic bq_t model(int n, bq_t ops);
    bq_t s;
    s = {};
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        int c;
        c = 0;
        for (int kk = 0; kk < n; kk++)
          c += int'($signed(ops[i*n + kk])) * int'($signed(ops[n*n + kk*n + j]));
        for (int b = 0; b < OB; b++) s.push_back(8'(c >>> (8*b)));
      end
    end
    return s;
  endfunction

  function automatic bq_t rand_ops(int n);
    bq_t q;
    q = {};
    for (int i = 0; i < 2*n*n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic load_ops(int d, bq_t ops, bit gaps);
    foreach (ops[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          iv[d] = 1'b0;
          ui[d] = 8'($urandom);
        end
      end
      @(negedge clk);
      ui[d] = ops[i];
      iv[d] = 1'b1;
    end
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  // Called half a cycle after the last load edge; counts cycles until out_valid is seen
  task automatic wait_out(int d, bit junk, int freeze, output int cyc);
    cyc = 0;
    if (freeze > 0) en[d] = 1'b0;
    while (!uio[d][2] && cyc < 100) begin
      if (junk) begin
        iv[d] = 1'b1;
        ui[d] = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (cyc == freeze) en[d] = 1'b1;
    end
    iv[d] = 1'b0;
    en[d] = 1'b1;
  endtask

  task automatic read_out(int d, int nb, bit stall, bit junk, output bq_t got);
    got = {};
    for (int i = 0; i < nb; i++) begin
      int         waits;
      logic [7:0] held;
      waits = 0;
      held  = uo[d];
      while (stall && waits < 4 && $urandom_range(0, 1) == 0) begin
        ack[d] = 1'b0;
        if (junk) begin
          iv[d] = 1'b1;
          ui[d] = 8'($urandom);
        end
        @(negedge clk);
        waits++;
        check("uo_hold", {24'h0, uo[d]}, {24'h0, held});
      end
      check("out_valid", {24'h0, uio[d]}, 32'h04);
      got.push_back(uo[d]);
      iv[d]  = 1'b0;
      ack[d] = 1'b1;
      @(negedge clk);
    end
    ack[d] = 1'b0;
    check("ready_after_read", {24'h0, uio[d]}, 32'h01);
  endtask

  task automatic cmp_stream(string name, bq_t got, bq_t exp);
    check($sformatf("%s_len", name), got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size())
        check($sformatf("%s_byte%0d", name, i), {24'h0, got[i]}, {24'h0, exp[i]});
    end
  endtask

  vec_t tbl [3];

  initial begin
    int  cyc;
    bq_t ops, exp, got, basic_ops, basic_exp;

    vectors     = 0;
    miscompares = 0;
    for (int d = 0; d < ND; d++) begin
      ui[d] = 8'h00; iv[d] = 1'b0; ack[d] = 1'b0; ab[d] = 1'b0; en[d] = 1'b1;
    end

    tbl[0] = '{name: "basic",
               ops: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
               exp: '{8'h13, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00,
                      8'h2B, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00}};
    tbl[1] = '{name: "neg_neg",
               ops: '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80},
               exp: '{8'h00, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00,
                      8'h00, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00}};
    tbl[2] = '{name: "neg_pos",
               ops: '{8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F},
               exp: '{8'h00, 8'h81, 8'hFF, 8'h00, 8'h81, 8'hFF,
                      8'h00, 8'h81, 8'hFF, 8'h00, 8'h81, 8'hFF}};

    basic_ops = {};
    basic_exp = {};
    foreach (tbl[0].ops[i]) basic_ops.push_back(tbl[0].ops[i]);
    foreach (tbl[0].exp[i]) basic_exp.push_back(tbl[0].exp[i]);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_uo", {24'h0, uo[0]}, 32'h00);
    check("reset_uio", {24'h0, uio[0]}, 32'h01);
    check("reset_oe", {24'h0, oe[0]}, 32'h07);
    check("reset_oe_n4", {24'h0, oe[2]}, 32'h07);
    reset = 1'b0;

    for (int t = 0; t < 3; t++) begin
      ops = {};
      exp = {};
      foreach (tbl[t].ops[i]) ops.push_back(tbl[t].ops[i]);
      foreach (tbl[t].exp[i]) exp.push_back(tbl[t].exp[i]);
      load_ops(0, ops, 1'b0);
      check({tbl[t].name, "_busy"}, {24'h0, uio[0]}, 32'h02);
      wait_out(0, 1'b0, 0, cyc);
      check({tbl[t].name, "_latency"}, cyc, 2);
      read_out(0, 12, 1'b0, 1'b0, got);
      cmp_stream(tbl[t].name, got, exp);
    end

    load_ops(0, basic_ops, 1'b1);
    wait_out(0, 1'b1, 0, cyc);
    check("bp_latency", cyc, 2);
    read_out(0, 12, 1'b1, 1'b1, got);
    cmp_stream("backpressure", got, basic_exp);

    load_ops(0, rand_ops(2).size() > 0 ? basic_ops : basic_ops, 1'b0);
    wait_out(0, 1'b0, 3, cyc);
    check("ena_freeze_latency", cyc, 5);
    read_out(0, 12, 1'b0, 1'b0, got);
    cmp_stream("ena_freeze", got, basic_exp);

    ops = rand_ops(2);
    load_ops(0, ops[0:4], 1'b0);
    check("partial_load_ready", {24'h0, uio[0]}, 32'h01);
    ab[0] = 1'b1;
    iv[0] = 1'b1;
    ui[0] = 8'hAA;
    @(negedge clk);
    ab[0] = 1'b0;
    iv[0] = 1'b0;
    check("abort_ready", {24'h0, uio[0]}, 32'h01);
    load_ops(0, basic_ops, 1'b0);
    wait_out(0, 1'b0, 0, cyc);
    read_out(0, 12, 1'b0, 1'b0, got);
    cmp_stream("after_abort", got, basic_exp);

    load_ops(0, basic_ops, 1'b0);
    wait_out(0, 1'b0, 0, cyc);
    check("pre_reset_uo", {24'h0, uo[0]}, 32'h13);
    #1 reset = 1'b1;
    #1;
    check("async_reset_uo", {24'h0, uo[0]}, 32'h00);
    check("async_reset_uio", {24'h0, uio[0]}, 32'h01);
    @(negedge clk);
    reset = 1'b0;

    ops = rand_ops(4);
    load_ops(2, ops, 1'b0);
    @(negedge clk);
    check("n4_busy", {24'h0, uio[2]}, 32'h02);
    #1 reset = 1'b1;
    #1;
    check("reset_mid_compute_uo", {24'h0, uo[2]}, 32'h00);
    check("reset_mid_compute_uio", {24'h0, uio[2]}, 32'h01);
    @(negedge clk);
    reset = 1'b0;
    load_ops(0, basic_ops, 1'b0);
    wait_out(0, 1'b0, 0, cyc);
    read_out(0, 12, 1'b0, 1'b0, got);
    cmp_stream("after_reset", got, basic_exp);

    ops = rand_ops(4);
    load_ops(2, ops, 1'b0);
    ab[2] = 1'b1;
    @(negedge clk);
    ab[2] = 1'b0;
    check("abort_compute_uio", {24'h0, uio[2]}, 32'h01);
    check("abort_compute_uo", {24'h0, uo[2]}, 32'h00);

    for (int r = 0; r < 9; r++) begin
      int d;
      int n;
      d   = r % 3;
      n   = dim(d);
      ops = rand_ops(n);
      exp = model(n, ops);
      load_ops(d, ops, r[0]);
      wait_out(d, r[1], 0, cyc);
      check($sformatf("rand%0d_n%0d_latency", r, n), cyc, n);
      read_out(d, n*n*OB, r[0], r[1], got);
      cmp_stream($sformatf("rand%0d_n%0d", r, n), got, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
